// File: rtl/dco_pkg.sv
// rtl/dco_pkg.sv - shared decode modes and half-period decode for the DCO bank
package dco_pkg;

  localparam logic MODE_PRIO = 1'b0;
  localparam logic MODE_BIN  = 1'b1;

  // Priority mode maps the leading one to a half-period; binary mode uses the code with a floor.
  function automatic int dco_half(input logic mode, input logic [31:0] code,
                                  input int prio_base, input int idle_half, input int min_half);
    int p;
    p = 0;
    if (mode == MODE_BIN) begin
      if (int'(code) < min_half) return min_half;
      return int'(code);
    end
    if (code == 32'd0) return idle_half;
    for (int b = 0; b < 32; b++) begin
      if (code[b]) p = b;
    end
    return prio_base + p;
  endfunction

endpackage

// File: rtl/dco_bank_if.sv
// rtl/dco_bank_if.sv - control, config and output bundle of the DCO bank
interface dco_bank_if #(
  parameter int N_CH   = 2,
  parameter int CODE_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              ena;
  logic [N_CH-1:0]   ch_en;
  logic              sync;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic              cfg_mode;
  logic [CODE_W-1:0] cfg_code;
  logic [N_CH-1:0]   dco_out;
  logic [N_CH-1:0]   rise_tick;

  modport master (
    output ena, ch_en, sync, cfg_we, cfg_ch, cfg_mode, cfg_code,
    input  dco_out, rise_tick
  );

  modport slave (
    input  ena, ch_en, sync, cfg_we, cfg_ch, cfg_mode, cfg_code,
    output dco_out, rise_tick
  );
endinterface

// File: rtl/dco_channel.sv
// rtl/dco_channel.sv - one oscillator channel: shadow config, half-period counter, output, rise tick
module dco_channel
  import dco_pkg::*;
#(
  parameter int CODE_W    = 8,
  parameter int CNT_W     = 8,
  parameter int PRIO_BASE = 3,
  parameter int IDLE_HALF = 50,
  parameter int MIN_HALF  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ena,
  input  logic              i_ch_en,
  input  logic              i_sync,
  input  logic              i_we,
  input  logic              i_mode,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_out,
  output logic              o_tick
);

  localparam logic [0:0] S_LOW  = 1'b0;
  localparam logic [0:0] S_HIGH = 1'b1;

  logic              r_mode;
  logic [CODE_W-1:0] r_code;
  logic [CNT_W-1:0]  r_hp;
  logic [CNT_W-1:0]  r_cnt;
  logic [0:0]        r_state;
  logic              r_tick;
  logic [CNT_W-1:0]  w_dec;

  assign w_dec = CNT_W'(dco_half(r_mode, 32'(r_code), PRIO_BASE, IDLE_HALF, MIN_HALF));

  // Shadow writes land alongside a boundary reload, so the reload always sees the old shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= MODE_PRIO;
      r_code  <= '0;
      r_hp    <= CNT_W'(IDLE_HALF);
      r_cnt   <= '0;
      r_state <= S_LOW;
      r_tick  <= 1'b0;
    end else if (!i_ena) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_we) begin
        r_mode <= i_mode;
        r_code <= i_code;
      end
      if (i_sync || !i_ch_en) begin
        r_cnt   <= '0;
        r_state <= S_LOW;
        r_hp    <= w_dec;
      end else if (r_cnt == r_hp) begin
        r_cnt   <= '0;
        r_hp    <= w_dec;
        r_state <= (r_state == S_LOW) ? S_HIGH : S_LOW;
        r_tick  <= (r_state == S_LOW);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_out  = r_state[0];
  assign o_tick = r_tick;

endmodule

// File: rtl/dco_bank.sv
// rtl/dco_bank.sv - N_CH-channel DCO bank with config address decode
module dco_bank
  import dco_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int CODE_W    = 8,
  parameter int CNT_W     = 8,
  parameter int PRIO_BASE = 3,
  parameter int IDLE_HALF = 50,
  parameter int MIN_HALF  = 1
) (
  input logic       clk,
  input logic       rst,
  dco_bank_if.slave bus
);

  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("dco_bank: N_CH must be 1..8");
  end
  if (IDLE_HALF > CNT_MAX || PRIO_BASE + CODE_W - 1 > CNT_MAX || (1 << CODE_W) - 1 > CNT_MAX) begin : g_bad_cnt
    $error("dco_bank: CNT_W too narrow for the decoded half-period");
  end
  if (MIN_HALF < 0 || MIN_HALF > CNT_MAX) begin : g_bad_min
    $error("dco_bank: MIN_HALF out of counter range");
  end

  logic [N_CH-1:0] w_we;
  logic [N_CH-1:0] w_out;
  logic [N_CH-1:0] w_tick;

  // Addresses at or beyond N_CH match no channel, so such writes fall away.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_we[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    dco_channel #(
      .CODE_W    (CODE_W),
      .CNT_W     (CNT_W),
      .PRIO_BASE (PRIO_BASE),
      .IDLE_HALF (IDLE_HALF),
      .MIN_HALF  (MIN_HALF)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_ena   (bus.ena),
      .i_ch_en (bus.ch_en[i]),
      .i_sync  (bus.sync),
      .i_we    (w_we[i]),
      .i_mode  (bus.cfg_mode),
      .i_code  (bus.cfg_code),
      .o_out   (w_out[i]),
      .o_tick  (w_tick[i])
    );
  end

  assign bus.dco_out   = w_out;
  assign bus.rise_tick = w_tick;

endmodule

// File: tb/tb_dco_bank.sv
// tb/tb_dco_bank.sv - directed self-checking bench for dco_bank
module tb_dco_bank;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dco_bank_if #(.N_CH(2), .CODE_W(8)) bus ();

  dco_bank #(
    .N_CH(2), .CODE_W(8), .CNT_W(8), .PRIO_BASE(3), .IDLE_HALF(50), .MIN_HALF(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic ch, input logic mode, input logic [7:0] code);
    bus.cfg_ch   = ch;
    bus.cfg_mode = mode;
    bus.cfg_code = code;
    bus.cfg_we   = 1'b1;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_toggle(input int ch, output int n);
    logic prev;
    prev = bus.dco_out[ch];
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.dco_out[ch] === prev && n < 300);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    bus.ena = 1'b1; bus.ch_en = 2'b00; bus.sync = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_ch = 1'b0; bus.cfg_mode = 1'b0; bus.cfg_code = 8'h00;
    repeat (3) tick();
    total++;
    if (bus.dco_out !== 2'b00) begin bad++; $display("FAIL reset_out got=%b exp=00", bus.dco_out); end
    total++;
    if (bus.rise_tick !== 2'b00) begin bad++; $display("FAIL reset_tick got=%b exp=00", bus.rise_tick); end
    bus.ch_en = 2'b01;
    rst = 1'b0;
    wait_toggle(0, n);
    total++;
    if (n !== 51) begin bad++; $display("FAIL idle_first_half got=%0d exp=51", n); end
    total++;
    if (bus.rise_tick !== 2'b01) begin bad++; $display("FAIL idle_rise_tick got=%b exp=01", bus.rise_tick); end
    wait_toggle(0, n);
    total++;
    if (n !== 51) begin bad++; $display("FAIL idle_second_half got=%0d exp=51", n); end
    total++;
    if (bus.dco_out[1] !== 1'b0) begin bad++; $display("FAIL ch1_disabled got=%b exp=0", bus.dco_out[1]); end
  endtask

  task automatic test_priority();
    int n;
    cfg_write(1'b0, 1'b0, 8'h80);
    wait_toggle(0, n);
    total++;
    if (n !== 50) begin bad++; $display("FAIL prio80_finish_old got=%0d exp=50", n); end
    for (int k = 0; k < 2; k++) begin
      wait_toggle(0, n);
      total++;
      if (n !== 11) begin bad++; $display("FAIL prio80_half%0d got=%0d exp=11", k, n); end
    end
    cfg_write(1'b0, 1'b0, 8'h01);
    wait_toggle(0, n);
    total++;
    if (n !== 10) begin bad++; $display("FAIL prio01_finish_old got=%0d exp=10", n); end
    for (int k = 0; k < 2; k++) begin
      wait_toggle(0, n);
      total++;
      if (n !== 4) begin bad++; $display("FAIL prio01_half%0d got=%0d exp=4", k, n); end
    end
  endtask

  task automatic test_binary();
    int n;
    cfg_write(1'b1, 1'b1, 8'd20);
    tick();
    bus.ch_en = 2'b11;
    for (int k = 0; k < 2; k++) begin
      wait_toggle(1, n);
      total++;
      if (n !== 21) begin bad++; $display("FAIL bin20_half%0d got=%0d exp=21", k, n); end
    end
    cfg_write(1'b1, 1'b1, 8'd0);
    wait_toggle(1, n);
    total++;
    if (n !== 20) begin bad++; $display("FAIL bin0_finish_old got=%0d exp=20", n); end
    for (int k = 0; k < 2; k++) begin
      wait_toggle(1, n);
      total++;
      if (n !== 2) begin bad++; $display("FAIL bin0_clamp_half%0d got=%0d exp=2", k, n); end
    end
  endtask

  task automatic test_mid_phase();
    int   n;
    logic prev;
    wait_toggle(0, n);
    cfg_write(1'b0, 1'b0, 8'h80);
    wait_toggle(0, n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL mid_setup_old got=%0d exp=3", n); end
    wait_toggle(0, n);
    total++;
    if (n !== 11) begin bad++; $display("FAIL mid_setup_new got=%0d exp=11", n); end
    repeat (3) tick();
    cfg_write(1'b0, 1'b0, 8'h01);
    wait_toggle(0, n);
    total++;
    if (n !== 7) begin bad++; $display("FAIL mid_write_remaining got=%0d exp=7", n); end
    wait_toggle(0, n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL mid_write_next got=%0d exp=4", n); end
    repeat (3) tick();
    prev = bus.dco_out[0];
    cfg_write(1'b0, 1'b0, 8'h80);
    total++;
    if (bus.dco_out[0] !== ~prev) begin bad++; $display("FAIL coincident_toggle got=%b exp=%b", bus.dco_out[0], ~prev); end
    wait_toggle(0, n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL coincident_old_kept got=%0d exp=4", n); end
    wait_toggle(0, n);
    total++;
    if (n !== 11) begin bad++; $display("FAIL coincident_new_applied got=%0d exp=11", n); end
  endtask

  task automatic test_sync();
    int n;
    cfg_write(1'b1, 1'b1, 8'd10);
    wait_toggle(1, n);
    wait_toggle(1, n);
    n = 0;
    while (bus.dco_out[0] !== 1'b1 && n < 50) begin tick(); n++; end
    total++;
    if (bus.dco_out[0] !== 1'b1) begin bad++; $display("FAIL sync_precondition got=%b exp=1", bus.dco_out[0]); end
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    total++;
    if (bus.dco_out !== 2'b00) begin bad++; $display("FAIL sync_clear got=%b exp=00", bus.dco_out); end
    n = 0;
    do begin tick(); n++; end while (bus.dco_out === 2'b00 && n < 100);
    total++;
    if (n !== 11) begin bad++; $display("FAIL sync_rise_delay got=%0d exp=11", n); end
    total++;
    if (bus.dco_out !== 2'b11) begin bad++; $display("FAIL sync_in_phase got=%b exp=11", bus.dco_out); end
    total++;
    if (bus.rise_tick !== 2'b11) begin bad++; $display("FAIL sync_rise_tick got=%b exp=11", bus.rise_tick); end
    tick();
    total++;
    if (bus.rise_tick !== 2'b00) begin bad++; $display("FAIL rise_tick_width got=%b exp=00", bus.rise_tick); end
  endtask

  task automatic test_freeze();
    int         n;
    logic [1:0] held;
    repeat (3) tick();
    held = bus.dco_out;
    bus.ena = 1'b0;
    bus.cfg_ch = 1'b0; bus.cfg_mode = 1'b0; bus.cfg_code = 8'h01; bus.cfg_we = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (bus.dco_out !== held || bus.rise_tick !== 2'b00) begin
        bad++;
        $display("FAIL freeze_cycle%0d got=%b/%b exp=%b/00", k, bus.dco_out, bus.rise_tick, held);
      end
    end
    bus.cfg_we = 1'b0;
    bus.ena = 1'b1;
    wait_toggle(0, n);
    total++;
    if (n !== 7) begin bad++; $display("FAIL freeze_resume got=%0d exp=7", n); end
    wait_toggle(0, n);
    total++;
    if (n !== 11) begin bad++; $display("FAIL freeze_write_ignored got=%0d exp=11", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1;
    tick();
    total++;
    if (bus.dco_out !== 2'b00 || bus.rise_tick !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset_clear got=%b/%b exp=00/00", bus.dco_out, bus.rise_tick);
    end
    bus.ch_en = 2'b01;
    rst = 1'b0;
    wait_toggle(0, n);
    total++;
    if (n !== 51) begin bad++; $display("FAIL mid_reset_default_cfg got=%0d exp=51", n); end
    total++;
    if (bus.dco_out !== 2'b01) begin bad++; $display("FAIL mid_reset_outputs got=%b exp=01", bus.dco_out); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_priority();
    test_binary();
    test_mid_phase();
    test_sync();
    test_freeze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
